cvxif_bcd_sequencer: RTL and testbench

//  Sequencing controller for the CV-X-IF BCD coprocessor datapath.
//  - Buffers accepted BCDfromBIN / BCDADD issue requests in a small FIFO.
//  - Runs one request at a time on a shared iterative BCD engine.
//  - Returns one result per request on a valid/ready result channel.
//  - Sits between the coprocessor issue decoder and the core writeback path.

---
 rtl/cvxif_bcd_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_cvxif_bcd_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_bcd_sequencer.sv
// Request FIFO plus a shared iterative BCD engine (double-dabble / digit-serial add).
// Optional macro CVXIF_BCD_DIGIT_CHECK_EN flags BCDADD operands containing nibbles > 9.
module cvxif_bcd_sequencer #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int ID_WIDTH   = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [3:0]          issue_opcode_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [4:0]          issue_rd_i,
  input  logic [XLEN-1:0]     issue_rs1_i,
  input  logic [XLEN-1:0]     issue_rs2_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [4:0]          result_rd_o,
  output logic                result_we_o,
  output logic [XLEN-1:0]     result_data_o,
  output logic                result_exc_o,
  output logic                busy_o
);

  localparam int NDIG   = XLEN / 4;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int ITER_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CONV, ADD, DONE} state_t;

  typedef struct packed {
    logic [3:0]          opcode;
    logic [ID_WIDTH-1:0] id;
    logic [4:0]          rd;
    logic [XLEN-1:0]     rs1;
    logic [XLEN-1:0]     rs2;
  } req_t;

  req_t                fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    fifo_cnt;
  logic                fifo_full, fifo_empty, push, pop;
  req_t                head, incoming;

  state_t              state_q, state_d;
  logic [ITER_W-1:0]   iter_q;
  logic [ID_WIDTH-1:0] id_q;
  logic [4:0]          rd_q;
  logic [XLEN-1:0]     op_a_q, op_b_q, acc_q, dabble_adj;
  logic                carry_q, we_q, exc_q, bad_digit;
  logic [4:0]          add_sum;
  logic [3:0]          add_digit;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full     = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign fifo_empty    = (fifo_cnt == '0);
  assign issue_ready_o = !fifo_full && !flush_i;
  assign push          = issue_valid_i && issue_ready_o;
  assign head          = fifo_mem[rd_ptr];
  assign incoming      = '{opcode: issue_opcode_i, id: issue_id_i, rd: issue_rd_i,
                           rs1: issue_rs1_i, rs2: issue_rs2_i};

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= incoming;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (flush_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

`ifdef CVXIF_BCD_DIGIT_CHECK_EN
  function automatic logic has_bad_digit(input logic [XLEN-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NDIG; i++)
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  assign bad_digit = (head.opcode == 4'd2) &&
                     (has_bad_digit(head.rs1) || has_bad_digit(head.rs2));
`else
  assign bad_digit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            case (head.opcode)
              4'd1:    state_d = CONV;
              4'd2:    state_d = ADD;
              default: state_d = DONE;
            endcase
          end
        end
        CONV, ADD: if (iter_q == '0) state_d = DONE;
        DONE:      if (result_ready_i) state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pop            = (state_q == IDLE) && !fifo_empty && !flush_i;
    result_valid_o = (state_q == DONE);
    busy_o         = !fifo_empty || (state_q != IDLE);
  end

  // Double-dabble correction: every digit >= 5 gets +3 before the shift.
  always_comb begin
    dabble_adj = acc_q;
    for (int i = 0; i < NDIG; i++)
      if (acc_q[4*i +: 4] >= 4'd5) dabble_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
  end

  assign add_sum   = {1'b0, op_a_q[3:0]} + {1'b0, op_b_q[3:0]} + {4'b0, carry_q};
  assign add_digit = (add_sum > 5'd9) ? 4'(add_sum - 5'd10) : add_sum[3:0];

  // Sum digits enter at the top so digit 0 lands at the bottom after NDIG steps.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      iter_q  <= '0;
      id_q    <= '0;
      rd_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      we_q    <= 1'b0;
      exc_q   <= 1'b0;
    end else if (pop) begin
      iter_q  <= (head.opcode == 4'd1) ? ITER_W'(XLEN - 1) : ITER_W'(NDIG - 1);
      id_q    <= head.id;
      rd_q    <= head.rd;
      op_a_q  <= head.rs1;
      op_b_q  <= head.rs2;
      acc_q   <= '0;
      carry_q <= 1'b0;
      we_q    <= ((head.opcode == 4'd1) || (head.opcode == 4'd2)) && !bad_digit;
      exc_q   <= bad_digit;
    end else if (state_q == CONV) begin
      acc_q   <= {dabble_adj[XLEN-2:0], op_a_q[XLEN-1]};
      op_a_q  <= {op_a_q[XLEN-2:0], 1'b0};
      iter_q  <= iter_q - 1'b1;
    end else if (state_q == ADD) begin
      acc_q   <= {add_digit, acc_q[XLEN-1:4]};
      op_a_q  <= op_a_q >> 4;
      op_b_q  <= op_b_q >> 4;
      carry_q <= (add_sum > 5'd9);
      iter_q  <= iter_q - 1'b1;
    end
  end

  assign result_id_o   = result_valid_o ? id_q : '0;
  assign result_rd_o   = result_valid_o ? rd_q : '0;
  assign result_we_o   = result_valid_o && we_q;
  assign result_data_o = (result_valid_o && we_q) ? acc_q : '0;
  assign result_exc_o  = result_valid_o && exc_q;

endmodule

// File: tb/tb_cvxif_bcd_sequencer.sv
// Bench for cvxif_bcd_sequencer: directed latency/ordering/flush/reset cases plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_cvxif_bcd_sequencer;

  localparam int XLEN       = 32;
  localparam int FIFO_DEPTH = 2;
  localparam int ID_WIDTH   = 3;
  localparam int NDIG       = XLEN / 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                flush, issue_valid, issue_ready, result_valid, result_ready;
  logic [3:0]          issue_opcode;
  logic [ID_WIDTH-1:0] issue_id, result_id;
  logic [4:0]          issue_rd, result_rd;
  logic [XLEN-1:0]     issue_rs1, issue_rs2, result_data;
  logic                result_we, result_exc, busy;

  int n_checks = 0;
  int n_pass   = 0;

  cvxif_bcd_sequencer #(.XLEN(XLEN), .FIFO_DEPTH(FIFO_DEPTH), .ID_WIDTH(ID_WIDTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_opcode_i(issue_opcode),
    .issue_id_i(issue_id), .issue_rd_i(issue_rd), .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2),
    .result_valid_o(result_valid), .result_ready_i(result_ready), .result_id_o(result_id),
    .result_rd_o(result_rd), .result_we_o(result_we), .result_data_o(result_data),
    .result_exc_o(result_exc), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference arithmetic straight from the decimal definitions.
  function automatic logic [XLEN-1:0] ref_bin2bcd(input logic [XLEN-1:0] bin);
    longint unsigned v;
    logic [XLEN-1:0] r;
    v = bin;
    r = '0;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] ref_bcdadd(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    int s, c;
    r = '0;
    c = 0;
    for (int i = 0; i < NDIG; i++) begin
      s = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + c;
      if (s > 9) begin r[4*i +: 4] = 4'((s - 10) % 16); c = 1; end
      else       begin r[4*i +: 4] = 4'(s);             c = 0; end
    end
    return r;
  endfunction

  function automatic bit ref_bad(input logic [XLEN-1:0] v);
    for (int i = 0; i < NDIG; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  typedef struct {
    logic [3:0]          op;
    logic [ID_WIDTH-1:0] id;
    logic [4:0]          rd;
    logic [XLEN-1:0]     a, b;
  } req_s;

  req_s                m_q[$];
  req_s                m_new, m_cur;
  int                  m_run = 0;
  int                  m_left = 0;
  bit                  m_push;
  logic [ID_WIDTH-1:0] m_id;
  logic [4:0]          m_rd;
  logic                m_we, m_exc;
  logic [XLEN-1:0]     m_data;

  task automatic startJob(input req_s r);
    m_id = r.id; m_rd = r.rd; m_we = 1'b0; m_exc = 1'b0; m_data = '0;
    if (r.op == 4'd1) begin
      m_we = 1'b1; m_data = ref_bin2bcd(r.a); m_left = XLEN;
    end else if (r.op == 4'd2) begin
      m_left = NDIG;
`ifdef CVXIF_BCD_DIGIT_CHECK_EN
      if (ref_bad(r.a) || ref_bad(r.b)) m_exc = 1'b1;
      else begin m_we = 1'b1; m_data = ref_bcdadd(r.a, r.b); end
`else
      m_we = 1'b1; m_data = ref_bcdadd(r.a, r.b);
`endif
    end else begin
      m_left = 0;
    end
    m_run = (m_left == 0) ? 2 : 1;
  endtask

  // Model: m_run 0 = idle, 1 = computing (m_left cycles remain), 2 = result offered.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_run = 0;
      m_left = 0;
    end else begin
      m_push = issue_valid && (m_q.size() < FIFO_DEPTH) && !flush;
      m_new = '{op: issue_opcode, id: issue_id, rd: issue_rd, a: issue_rs1, b: issue_rs2};
      if (flush) begin
        m_q.delete();
        m_run = 0;
      end else begin
        if (m_run == 0) begin
          if (m_q.size() > 0) begin
            m_cur = m_q.pop_front();
            startJob(m_cur);
          end
        end else if (m_run == 1) begin
          m_left--;
          if (m_left == 0) m_run = 2;
        end else if (result_ready) begin
          m_run = 0;
        end
        if (m_push) m_q.push_back(m_new);
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("issue_ready", issue_ready, (m_q.size() < FIFO_DEPTH) && !flush);
    checkOutput("result_valid", result_valid, m_run == 2);
    checkOutput("busy", busy, (m_q.size() != 0) || (m_run != 0));
    if (m_run == 2) begin
      checkOutput("result_id", result_id, m_id);
      checkOutput("result_rd", result_rd, m_rd);
      checkOutput("result_we", result_we, m_we);
      checkOutput("result_data", result_data, m_data);
      checkOutput("result_exc", result_exc, m_exc);
    end
  end

  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [ID_WIDTH-1:0] id,
                               input logic [4:0] rd, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    issue_valid = v; issue_opcode = op; issue_id = id; issue_rd = rd; issue_rs1 = a; issue_rs2 = b;
  endtask

  task automatic waitIdle();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    checkOutput("idle before directed case", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  // Issue one request in cycle 0 and return the cycle in which result_valid rises.
  task automatic runOne(input logic [3:0] op, input logic [ID_WIDTH-1:0] id,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, output int lat);
    lat = -1;
    applyStimulus(1'b1, op, id, 5'd7, a, b);
    @(posedge clk); #1;
    applyStimulus(1'b0, 4'd0, '0, 5'd0, '0, '0);
    for (int c = 1; c < 200; c++) begin
      @(negedge clk);
      if (result_valid) begin lat = c; break; end
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [XLEN-1:0] randBcd();
    logic [XLEN-1:0] r;
    for (int i = 0; i < NDIG; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat, seen, r;
    logic [ID_WIDTH-1:0] ids[$];
    logic [XLEN-1:0]     datas[$];

    rst_n = 1'b0; flush = 1'b0; result_ready = 1'b1;
    applyStimulus(1'b0, 4'd0, '0, 5'd0, '0, '0);

    checkOutput("model bin2bcd 0xFF", ref_bin2bcd(32'h000000FF), 64'h255);
    checkOutput("model bin2bcd 123456789", ref_bin2bcd(32'h075BCD15), 64'h23456789);
    checkOutput("model bcdadd 19+23", ref_bcdadd(32'h19, 32'h23), 64'h42);
    checkOutput("model bcdadd wrap", ref_bcdadd(32'h99999999, 32'h1), 64'h0);
    checkOutput("model bcdadd A+1", ref_bcdadd(32'hA, 32'h1), 64'h11);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset issue_ready", issue_ready, 1'b1);
    checkOutput("reset result_valid", result_valid, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset result_data", result_data, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    runOne(4'd1, 3'd1, 32'h000000FF, '0, lat);
    checkOutput("T1 latency", lat, XLEN + 2);
    checkOutput("T1 data", result_data, 64'h255);
    checkOutput("T1 we", result_we, 1'b1);
    waitIdle();
    runOne(4'd2, 3'd2, 32'h19, 32'h23, lat);
    checkOutput("T2 latency", lat, NDIG + 2);
    checkOutput("T2 data", result_data, 64'h42);
    waitIdle();
    runOne(4'd2, 3'd3, 32'h99999999, 32'h1, lat);
    checkOutput("T2 wrap data", result_data, 64'h0);
    waitIdle();
    runOne(4'd1, 3'd4, 32'h075BCD15, '0, lat);
    checkOutput("T3 data", result_data, 64'h23456789);
    waitIdle();
    runOne(4'd0, 3'd5, 32'h1234, 32'h5678, lat);
    checkOutput("T3 illegal latency", lat, 2);
    checkOutput("T3 illegal we", result_we, 1'b0);
    checkOutput("T3 illegal data", result_data, 64'h0);
    waitIdle();
    runOne(4'd2, 3'd6, 32'hA, 32'h1, lat);
`ifdef CVXIF_BCD_DIGIT_CHECK_EN
    checkOutput("T6 exc", result_exc, 1'b1);
    checkOutput("T6 we", result_we, 1'b0);
    checkOutput("T6 data", result_data, 64'h0);
`else
    checkOutput("T6 exc", result_exc, 1'b0);
    checkOutput("T6 data", result_data, 64'h11);
`endif
    checkOutput("T6 latency", lat, NDIG + 2);
    waitIdle();

    // Backpressure: three requests queue up behind a stalled result channel.
    result_ready = 1'b0;
    applyStimulus(1'b1, 4'd2, 3'd1, 5'd1, 32'h12, 32'h34);
    @(negedge clk); checkOutput("T4 issue 1 ready", issue_ready, 1'b1);
    @(posedge clk); #1;
    applyStimulus(1'b1, 4'd1, 3'd2, 5'd2, 32'd12345, '0);
    @(negedge clk); checkOutput("T4 issue 2 ready", issue_ready, 1'b1);
    @(posedge clk); #1;
    applyStimulus(1'b1, 4'd0, 3'd3, 5'd3, '0, '0);
    @(negedge clk); checkOutput("T4 issue 3 ready", issue_ready, 1'b1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 4'd0, '0, 5'd0, '0, '0);
    @(negedge clk); checkOutput("T4 full stall", issue_ready, 1'b0);
    for (int c = 0; c < 40 && !result_valid; c++) @(negedge clk);
    repeat (5) begin
      checkOutput("T4 held id", result_id, 3'd1);
      checkOutput("T4 held data", result_data, 64'h46);
      @(negedge clk);
    end
    @(posedge clk); #1;
    result_ready = 1'b1;
    for (int c = 0; c < 300 && ids.size() < 3; c++) begin
      @(negedge clk);
      if (result_valid) begin ids.push_back(result_id); datas.push_back(result_data); end
      @(posedge clk); #1;
    end
    checkOutput("T4 result count", ids.size(), 3);
    if (ids.size() == 3) begin
      checkOutput("T4 order 1", ids[0], 3'd1);
      checkOutput("T4 order 2", ids[1], 3'd2);
      checkOutput("T4 order 3", ids[2], 3'd3);
      checkOutput("T4 data 2", datas[1], 64'h12345);
      checkOutput("T4 data 3", datas[2], 64'h0);
    end
    waitIdle();

    // Flush while converting with one request waiting behind it.
    applyStimulus(1'b1, 4'd1, 3'd4, 5'd4, 32'hDEADBEEF, '0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 4'd2, 3'd5, 5'd5, 32'h11, 32'h22);
    @(posedge clk); #1;
    applyStimulus(1'b0, 4'd0, '0, 5'd0, '0, '0);
    repeat (5) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("T5 busy after flush", busy, 1'b0);
    seen = 0;
    repeat (60) begin @(negedge clk); if (result_valid) seen++; end
    checkOutput("T5 no result after flush", seen, 0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of an ADD.
    applyStimulus(1'b1, 4'd2, 3'd6, 5'd6, 32'h55, 32'h55);
    @(posedge clk); #1;
    applyStimulus(1'b0, 4'd0, '0, 5'd0, '0, '0);
    repeat (4) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("T5 reset issue_ready", issue_ready, 1'b1);
    checkOutput("T5 reset valid", result_valid, 1'b0);
    checkOutput("T5 reset busy", busy, 1'b0);
    checkOutput("T5 reset id", result_id, '0);
    checkOutput("T5 reset rd", result_rd, '0);
    checkOutput("T5 reset we", result_we, 1'b0);
    checkOutput("T5 reset data", result_data, '0);
    checkOutput("T5 reset exc", result_exc, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin @(negedge clk); if (result_valid) seen++; end
    checkOutput("T5 no result after reset", seen, 0);
    @(posedge clk); #1;

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      r = $urandom_range(0, 9);
      applyStimulus($urandom_range(0, 1) == 1,
                    (r < 4) ? 4'd1 : (r < 8) ? 4'd2 : (r == 8) ? 4'd0 : 4'(r),
                    ID_WIDTH'($urandom), 5'($urandom),
                    ($urandom_range(0, 3) == 0) ? XLEN'($urandom) : randBcd(),
                    ($urandom_range(0, 3) == 0) ? XLEN'($urandom) : randBcd());
      result_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 59) == 0);
      @(posedge clk); #1;
    end
    flush = 1'b0;
    result_ready = 1'b1;
    applyStimulus(1'b0, 4'd0, '0, 5'd0, '0, '0);
    waitIdle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
